// File: rtl/arb_pkg.sv
// Shared types and default sizing for the asynchronous-request arbiter.
package arb_pkg;

    localparam int unsigned DEF_NUM_REQ        = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/req_sync.sv
// Two-flop synchronizer for one request line, cleared to 0 on reset.
module req_sync (
    input  logic clk,
    input  logic n_rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous level
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/async_req_arbiter.sv
// Round-robin arbiter for unsynchronized request lines sharing one resource.
// Each rising request edge is synchronized, captured as a pending bit and
// served one grant at a time until the resource pulses done.
// Optional build macro ARB_TIMEOUT_EN: aborts a grant held too long and
// pulses timeout_err; without it grants are held until done.
module async_req_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_REQ-1:0]         async_req,
    input  logic                       done,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    // Reject parameter values outside the supported range at elaboration
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("async_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    logic [NUM_REQ-1:0] req_sync_w;
    logic [NUM_REQ-1:0] sync_prev_q;
    logic [NUM_REQ-1:0] rise;
    logic [NUM_REQ-1:0] clr;
    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] pending_d;

    arb_state_e         state_q;
    arb_state_e         state_d;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] grant_d;
    logic [ID_W-1:0]    grant_id_q;
    logic [ID_W-1:0]    grant_id_d;
    logic               busy_q;
    logic               busy_d;
    logic [ID_W-1:0]    last_id_q;
    logic [ID_W-1:0]    last_id_d;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    cand;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               terr_q;
    logic               terr_d;
`endif

    // One synchronizer per request line
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sync
        req_sync u_req_sync (
            .clk    (clk),
            .n_rst  (n_rst),
            .async_i(async_req[gi]),
            .sync_o (req_sync_w[gi])
        );
    end

    assign rise = req_sync_w & ~sync_prev_q;

    // Round-robin winner: first pending index scanning upward from last_id+1
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last_id_q) + k) % NUM_REQ);
            if (!win_found && pending_q[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Grant FSM next-state and output decode; pending clear follows the grant
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        last_id_d  = last_id_q;
        clr        = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        terr_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = GRANT;
                    grant_d    = NUM_REQ'(1) << win_id;
                    grant_id_d = win_id;
                    busy_d     = 1'b1;
                    last_id_d  = win_id;
                    clr        = NUM_REQ'(1) << win_id;
`ifdef ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            GRANT: begin
                if (done) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
        endcase
        // A fresh edge in the same cycle as its own clear stays pending
        pending_d = (pending_q & ~clr) | rise;
    end

    // State, grant and request bookkeeping registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_id_q  <= '0;
            busy_q      <= 1'b0;
            last_id_q   <= ID_W'(NUM_REQ - 1);
            pending_q   <= '0;
            sync_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            busy_q      <= busy_d;
            last_id_q   <= last_id_d;
            pending_q   <= pending_d;
            sync_prev_q <= req_sync_w;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Grant-age counter and abort pulse
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_async_req_arbiter.sv
// Bench for async_req_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_async_req_arbiter;

    localparam int N   = 4;
    localparam int TO  = 16;
    localparam int IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           n_rst;
    logic [N-1:0]   async_req;
    logic           done;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           timeout_err;

    int tests;
    int fails;

    always #5 clk = ~clk;

    async_req_arbiter #(
        .NUM_REQ       (N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .async_req  (async_req),
        .done       (done),
        .grant      (grant),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    // Behavioural model: a request event on a line driven before edge e is
    // pending from edge e+2; the model steps once per clock edge.
    typedef struct {
        int line;
        int due;
    } ev_t;

    ev_t          evq[$];
    bit           m_pend[N];
    bit           m_busy;
    int           m_id;
    int           m_last;
    int           m_age;
    bit           m_terr;
    int           edge_n;
    logic [N-1:0] req_prev;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_busy   = 1'b0;
        m_id     = 0;
        m_last   = N - 1;
        m_age    = 0;
        m_terr   = 1'b0;
        req_prev = '0;
        evq.delete();
    endtask

    task automatic model_step();
        bit found;
        int j;
        m_terr = 1'b0;
        found  = 1'b0;
        if (m_busy) begin
            if (done) m_busy = 1'b0;
`ifdef ARB_TIMEOUT_EN
            else if (m_age == TO + 1) begin
                m_busy = 1'b0;
                m_terr = 1'b1;
            end else m_age++;
`endif
        end else begin
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (!found && m_pend[j]) begin
                    found     = 1'b1;
                    m_busy    = 1'b1;
                    m_id      = j;
                    m_last    = j;
                    m_pend[j] = 1'b0;
                    m_age     = 1;
                end
            end
        end
        for (int k = evq.size() - 1; k >= 0; k--) begin
            if (evq[k].due == edge_n) begin
                m_pend[evq[k].line] = 1'b1;
                evq.delete(k);
            end
        end
    endtask

    // Drive one cycle of inputs from a falling edge, step model, return at next falling edge
    task automatic tick(input logic [N-1:0] r, input logic d);
        for (int i = 0; i < N; i++)
            if (r[i] && !req_prev[i]) evq.push_back('{line: i, due: edge_n + 3});
        req_prev  = r;
        async_req = r;
        done      = d;
        @(posedge clk);
        edge_n++;
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_grant(input logic [N-1:0] r, input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget; c++) begin
            if (n < 0) begin
                tick(r, 1'b0);
                if (grant !== '0) n = c;
            end
        end
    endtask

    task automatic do_reset();
        async_req = '0;
        done      = 1'b0;
        n_rst     = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (grant !== '0) begin fails++; $display("FAIL reset_grant: got %b expected 0", grant); end
        tests++; if (grant_id !== '0) begin fails++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        do_reset();
        repeat (3) tick(4'b0000, 1'b1);
        tests++; if (grant !== '0 || busy !== 1'b0) begin fails++; $display("FAIL idle_done_ignored: got grant=%b busy=%b expected 0/0", grant, busy); end
    endtask

    task automatic test_single();
        do_reset();
        repeat (3) tick(4'b0001, 1'b0);
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL single_early: got %b expected 0000", grant); end
        tick(4'b0001, 1'b0);
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b expected 0001", grant); end
        tests++; if (grant_id !== IDW'(0)) begin fails++; $display("FAIL single_id: got %0d expected 0", grant_id); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", busy); end
        repeat (4) tick(4'b0001, 1'b0);
        tests++; if (grant !== 4'b0001 || busy !== 1'b1) begin fails++; $display("FAIL single_hold: got grant=%b busy=%b expected 0001/1", grant, busy); end
        tick(4'b0001, 1'b1);
        tests++; if (grant !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL single_release: got grant=%b busy=%b expected 0000/0", grant, busy); end
        repeat (3) tick(4'b0000, 1'b0);
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL single_no_regrant: got %b expected 0000", grant); end
    endtask

    task automatic test_round_robin();
        int n;
        logic [N-1:0] eg;
        do_reset();
        tick(4'b1111, 1'b0);
        for (int k = 0; k < N; k++) begin
            wait_grant(4'b1111, 8, n);
            eg = '0;
            eg[k] = 1'b1;
            tests++; if (n != ((k == 0) ? 3 : 1)) begin fails++; $display("FAIL rr_latency[%0d]: got %0d cycles expected %0d", k, n, (k == 0) ? 3 : 1); end
            tests++; if (grant !== eg || grant_id !== IDW'(k)) begin fails++; $display("FAIL rr_order[%0d]: got grant=%b id=%0d expected grant=%b id=%0d", k, grant, grant_id, eg, k); end
            tick(4'b1111, 1'b0);
            tick(4'b1111, 1'b1);
            tests++; if (grant !== '0) begin fails++; $display("FAIL rr_gap[%0d]: got %b expected 0000", k, grant); end
        end
        tick(4'b0000, 1'b0);
    endtask

    task automatic test_wrap();
        int n;
        tick(4'b0110, 1'b0);
        wait_grant(4'b0110, 8, n);
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL wrap_first: got %b expected 0010", grant); end
        tick(4'b0110, 1'b0);
        tick(4'b0110, 1'b1);
        wait_grant(4'b0110, 8, n);
        tests++; if (grant !== 4'b0100 || n != 1) begin fails++; $display("FAIL wrap_second: got %b after %0d expected 0100 after 1", grant, n); end
        tick(4'b0110, 1'b1);
        tick(4'b0000, 1'b0);
        tick(4'b0001, 1'b0);
        wait_grant(4'b0001, 8, n);
        tests++; if (grant !== 4'b0001 || grant_id !== IDW'(0)) begin fails++; $display("FAIL wrap_zero: got grant=%b id=%0d expected 0001/0", grant, grant_id); end
        tick(4'b0001, 1'b1);
        tick(4'b0000, 1'b0);
    endtask

    task automatic test_during_grant();
        int n;
        int extra;
        tick(4'b0001, 1'b0);
        wait_grant(4'b0001, 8, n);
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL during_first: got %b expected 0001", grant); end
        // several edges on line 2 while line 0 owns the resource
        tick(4'b0101, 1'b0);
        tick(4'b0001, 1'b0);
        tick(4'b0101, 1'b0);
        tick(4'b0001, 1'b0);
        tick(4'b0101, 1'b0);
        repeat (3) tick(4'b0101, 1'b0);
        tests++; if (grant !== 4'b0001 || busy !== 1'b1) begin fails++; $display("FAIL during_stable: got grant=%b busy=%b expected 0001/1", grant, busy); end
        tick(4'b0101, 1'b1);
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL during_gap: got %b expected 0000", grant); end
        tick(4'b0101, 1'b0);
        tests++; if (grant !== 4'b0100 || grant_id !== IDW'(2)) begin fails++; $display("FAIL during_served: got grant=%b id=%0d expected 0100/2", grant, grant_id); end
        tick(4'b0101, 1'b1);
        extra = 0;
        repeat (5) begin
            tick(4'b0000, 1'b0);
            if (grant !== '0) extra++;
        end
        tests++; if (extra != 0) begin fails++; $display("FAIL during_collapse: got %0d extra grant cycles expected 0", extra); end
    endtask

    task automatic test_timeout();
        int n;
`ifdef ARB_TIMEOUT_EN
        tick(4'b1000, 1'b0);
        wait_grant(4'b1000, 8, n);
        repeat (TO) tick(4'b1000, 1'b0);
        tests++; if (grant !== 4'b1000 || timeout_err !== 1'b0) begin fails++; $display("FAIL to_held: got grant=%b terr=%b expected 1000/0", grant, timeout_err); end
        tick(4'b1000, 1'b0);
        tests++; if (grant !== 4'b0000 || timeout_err !== 1'b1) begin fails++; $display("FAIL to_abort: got grant=%b terr=%b expected 0000/1", grant, timeout_err); end
        tick(4'b1000, 1'b0);
        tests++; if (timeout_err !== 1'b0 || grant !== 4'b0000) begin fails++; $display("FAIL to_pulse_len: got grant=%b terr=%b expected 0000/0", grant, timeout_err); end
        tick(4'b0000, 1'b0);
        tick(4'b1000, 1'b0);
        wait_grant(4'b1000, 8, n);
        repeat (TO) tick(4'b1000, 1'b0);
        tick(4'b1000, 1'b1);
        tests++; if (grant !== 4'b0000 || timeout_err !== 1'b0) begin fails++; $display("FAIL to_done_wins: got grant=%b terr=%b expected 0000/0", grant, timeout_err); end
        tick(4'b0000, 1'b0);
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_done_wins_after: got terr=%b expected 0", timeout_err); end
`else
        int bad;
        tick(4'b1000, 1'b0);
        wait_grant(4'b1000, 8, n);
        bad = 0;
        repeat (3 * TO) begin
            tick(4'b1000, 1'b0);
            if (grant !== 4'b1000 || timeout_err !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL no_timeout_hold: got %0d bad cycles expected 0", bad); end
        tick(4'b1000, 1'b1);
        tests++; if (grant !== 4'b0000 || timeout_err !== 1'b0) begin fails++; $display("FAIL no_timeout_release: got grant=%b terr=%b expected 0000/0", grant, timeout_err); end
        tick(4'b0000, 1'b0);
`endif
    endtask

    task automatic test_reset_mid_grant();
        int n;
        int bad;
        do_reset();
        tick(4'b0100, 1'b0);
        wait_grant(4'b0100, 8, n);
        tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL rmid_setup: got %b expected 0100", grant); end
        repeat (4) tick(4'b0110, 1'b0);
        tick(4'b0000, 1'b0);
        #2 n_rst = 1'b0;
        #1;
        tests++; if (grant !== '0 || busy !== 1'b0 || grant_id !== '0 || timeout_err !== 1'b0) begin
            fails++; $display("FAIL rmid_async: got grant=%b busy=%b id=%0d terr=%b expected all 0", grant, busy, grant_id, timeout_err);
        end
        repeat (2) @(negedge clk);
        model_reset();
        n_rst = 1'b1;
        bad = 0;
        repeat (6) begin
            tick(4'b0000, 1'b0);
            if (grant !== '0 || timeout_err !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL rmid_no_stale: got %0d grant cycles expected 0", bad); end
        tick(4'b0010, 1'b0);
        wait_grant(4'b0010, 8, n);
        tests++; if (grant !== 4'b0010 || n != 3) begin fails++; $display("FAIL rmid_recover: got %b after %0d expected 0010 after 3", grant, n); end
        tick(4'b0010, 1'b1);
        tick(4'b0000, 1'b0);
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] eg;
        logic         d;
        do_reset();
        r = '0;
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0) r[i] = ~r[i];
            d = (c < 500) ? ($urandom_range(3) == 0) : ($urandom_range(23) == 0);
            tick(r, d);
            eg = '0;
            if (m_busy) eg[m_id] = 1'b1;
            tests++;
            if (grant !== eg || busy !== m_busy || timeout_err !== m_terr ||
                (m_busy && grant_id !== IDW'(m_id))) begin
                fails++;
                $display("FAIL random[%0d]: got grant=%b busy=%b id=%0d terr=%b expected grant=%b busy=%b id=%0d terr=%b",
                         c, grant, busy, grant_id, timeout_err, eg, m_busy, m_id, m_terr);
            end
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        edge_n    = 0;
        n_rst     = 1'b0;
        async_req = '0;
        done      = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_during_grant();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/async_req_arbiter.md
ASYNC_REQ_ARBITER -- requirements
Module: async_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, grant-hold limit in clocks; used only when ARB_TIMEOUT_EN is defined.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports listed first as follows.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 async_req  input  NUM_REQ  unsynchronized request lines; a rising edge on a line is one request event.
REQ-007 done  input  1  synchronous pulse from the shared resource ending the current grant.
REQ-008 grant  output  NUM_REQ  one-hot grant to the owning requester.
REQ-009 grant_id  output  $clog2(NUM_REQ)  binary index of the granted requester.
REQ-010 busy  output  1  high while any grant is held.
REQ-011 timeout_err  output  1  one-cycle pulse on grant abort; held 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-012 Each async_req bit SHALL pass through a two-flop synchronizer that resets to 0.
REQ-013 A 0->1 transition on a synchronized bit SHALL set pending[i] on the next edge.
REQ-014 The pending update SHALL be pending_next = (pending & ~clr) | rise; a new edge in the same cycle as its own clear leaves pending set.
REQ-015 The FSM SHALL have two states: IDLE and GRANT.
REQ-016 In IDLE with any pending bit set, the next edge SHALL enter GRANT, assert grant[w] and grant_id=w, set busy=1, and clear pending[w].
REQ-017 Winner w SHALL be chosen round-robin: the first pending index scanning upward, wrapping, from last_id+1.
REQ-018 last_id SHALL update to w on every grant.
REQ-019 In GRANT, grant, grant_id and busy SHALL hold stable until exit.
REQ-020 done=1 in GRANT SHALL return the FSM to IDLE on the next edge, with grant=0 and busy=0.
REQ-021 After any GRANT exit, grant SHALL be low for at least one cycle before the next grant.
REQ-022 done in IDLE SHALL be ignored.
REQ-023 Latency: with async_req rising before edge 0 and the FSM in IDLE, grant SHALL assert after edge 3.
REQ-024 Requests arriving during GRANT SHALL remain pending and are not lost; repeated edges on one line before service collapse into one pending request.

Reset
REQ-025 On n_rst low, regardless of clock or FSM state, the block SHALL immediately set grant=0, grant_id=0, busy=0, timeout_err=0, pending=0, synchronizers=0, state=IDLE, counter=0, and last_id=NUM_REQ-1.
REQ-026 Reset asserted mid-grant SHALL drop the grant without a timeout_err pulse and discard all pending requests.

Configuration
REQ-027 With macro ARB_TIMEOUT_EN defined, a counter SHALL clear on grant entry and increment each GRANT cycle.
REQ-028 With ARB_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYCLES without done, the FSM SHALL return to IDLE on the next edge, drop the grant, and pulse timeout_err for exactly one cycle.
REQ-029 With ARB_TIMEOUT_EN defined, done in the same cycle as the timeout SHALL win: normal exit, no error.
REQ-030 With ARB_TIMEOUT_EN undefined, no counter SHALL be built, a grant SHALL be held indefinitely until done, and timeout_err SHALL be tied to 0.

Structure
REQ-031 Package arb_pkg SHALL hold the state enum (IDLE, GRANT) and the default NUM_REQ and TIMEOUT_CYCLES constants.
REQ-032 Sub-module req_sync SHALL implement one two-flop, reset-low synchronizer bit and be instantiated NUM_REQ times.

Verification
REQ-033 Single request: async_req=0001 rises, done pulses 5 cycles after grant -> grant=0001 after edge 3, grant_id=0, busy=1, then grant=0 one edge after done.
REQ-034 Round-robin: all four lines rise together, done pulses 2 cycles after each grant -> grant order 0,1,2,3, with a one-cycle low gap between grants.
REQ-035 Wrap: last grant=3, then requests on 1 and 2 -> grant 1, then grant 2; then a request on 0 -> grant 0.
REQ-036 Request during grant: req2 rises while grant=0001 -> req2 pending, granted after done plus the one-cycle gap.
REQ-037 Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): no done -> grant drops, timeout_err is high exactly one cycle; repeat with done in the timeout cycle -> timeout_err stays 0.
REQ-038 Reset mid-grant: n_rst low while grant=0100 and req1 pending -> all outputs 0 immediately, and no grant after reset release until a new edge arrives.
